// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for one shared multi-cycle ALU. One operation runs at a time.
// Grants alternate under contention, and the result is held until its owner takes it.
module alu_share_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req1_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req1_shamt,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
  } alu_op_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t     state, state_nxt;
  alu_op_t    op_q, op0, op1;
  logic       last_grant, owner;
  logic [3:0] cnt;
  logic       gnt_vld, gnt_id, req_hs, rsp_hs;

  assign op0 = '{opcode: req0_opcode, a: req0_a, b: req0_b, shamt: req0_shamt};
  assign op1 = '{opcode: req1_opcode, a: req1_a, b: req1_b, shamt: req1_shamt};

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    gnt_vld = (state == IDLE) && (req0_valid || req1_valid);
    gnt_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  // Readies are masked by reset so every output reads 0 while reset is held.
  assign req0_ready = resetn && gnt_vld && !gnt_id;
  assign req1_ready = resetn && gnt_vld &&  gnt_id;
  assign req_hs     = gnt_vld;
  assign rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs)         state_nxt = EXEC;
      EXEC:    if (cnt == 4'd1)    state_nxt = RESP;
      RESP:    if (rsp_hs)         state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    alu_start  = (state == EXEC) && (cnt == LAT);
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) &&  owner;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      rsp_data   <= 32'd0;
    end else begin
      if (state == IDLE && req_hs) begin
        op_q       <= gnt_id ? op1 : op0;
        owner      <= gnt_id;
        last_grant <= gnt_id;
        cnt        <= LAT;
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) rsp_data <= alu_result;
      end
    end
  end

  // The ALU sees the latched operation, which stays put until the next grant.
  assign alu_opcode = op_q.opcode;
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_shamt  = op_q.shamt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one arbiter at ALU_LATENCY=1, one at ALU_LATENCY=4, each fed by a small reference ALU.
module tb_alu_share_arbiter;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd4:    return a << sh;
      default: return a ^ b;
    endcase
  endfunction

  // Latency-1 instance
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode, req0_shamt, req1_shamt;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  alu_opcode, alu_shamt;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data;
  logic        alu_start, rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, busy;

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b, alu_shamt);

  alu_share_arbiter #(.ALU_LATENCY(1)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_start(alu_start), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Latency-4 instance
  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [4:0]  b_req0_opcode, b_req1_opcode, b_req0_shamt, b_req1_shamt;
  logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
  logic [4:0]  b_alu_opcode, b_alu_shamt;
  logic [31:0] b_alu_a, b_alu_b, b_alu_result, b_rsp_data;
  logic        b_alu_start, b_rsp0_valid, b_rsp1_valid, b_rsp0_ready, b_rsp1_ready, b_busy;

  assign b_alu_result = alu_f(b_alu_opcode, b_alu_a, b_alu_b, b_alu_shamt);

  alu_share_arbiter #(.ALU_LATENCY(4)) dut4 (
    .clock(clock), .resetn(resetn),
    .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
    .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
    .req0_opcode(b_req0_opcode), .req1_opcode(b_req1_opcode),
    .req0_a(b_req0_a), .req0_b(b_req0_b), .req1_a(b_req1_a), .req1_b(b_req1_b),
    .req0_shamt(b_req0_shamt), .req1_shamt(b_req1_shamt),
    .alu_opcode(b_alu_opcode), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_shamt(b_alu_shamt),
    .alu_start(b_alu_start), .alu_result(b_alu_result),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid),
    .rsp0_ready(b_rsp0_ready), .rsp1_ready(b_rsp1_ready),
    .rsp_data(b_rsp_data), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready0"}, {31'd0, req0_ready}, 0);
    chk({tag, " ready1"}, {31'd0, req1_ready}, 0);
    chk({tag, " busy"},   {31'd0, busy}, 0);
    chk({tag, " start"},  {31'd0, alu_start}, 0);
    chk({tag, " rsp0v"},  {31'd0, rsp0_valid}, 0);
    chk({tag, " rsp1v"},  {31'd0, rsp1_valid}, 0);
    chk({tag, " alu_a"},  alu_a, 0);
    chk({tag, " alu_op"}, {27'd0, alu_opcode}, 0);
    chk({tag, " rsp_data"}, rsp_data, 0);
  endtask

  initial begin
    resetn = 1'b0;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    {req0_opcode, req1_opcode, req0_shamt, req1_shamt} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    {b_req0_valid, b_req1_valid, b_rsp0_ready, b_rsp1_ready} = '0;
    {b_req0_opcode, b_req1_opcode, b_req0_shamt, b_req1_shamt} = '0;
    {b_req0_a, b_req0_b, b_req1_a, b_req1_b} = '0;

    // Reset: outputs 0 even with a valid pending
    req0_valid = 1'b1;
    #2;
    chk_all_zero("reset");
    req0_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    tick();

    // Single op from req0, latency 1: 5+7=12
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    chk("A ready0@T", {31'd0, req0_ready}, 1);
    chk("A ready1@T", {31'd0, req1_ready}, 0);
    chk("A busy@T",   {31'd0, busy}, 0);
    tick(); req0_valid = 1'b0; #1;
    chk("A start@T+1", {31'd0, alu_start}, 1);
    chk("A busy@T+1",  {31'd0, busy}, 1);
    chk("A alu_a",     alu_a, 5);
    chk("A alu_b",     alu_b, 7);
    chk("A ready0@T+1", {31'd0, req0_ready}, 0);
    tick(); #1;
    chk("A rsp0v@T+2", {31'd0, rsp0_valid}, 1);
    chk("A data@T+2",  rsp_data, 12);
    chk("A start@T+2", {31'd0, alu_start}, 0);
    chk("A rsp1v@T+2", {31'd0, rsp1_valid}, 0);
    tick(); #1;
    chk("A rsp0v hold", {31'd0, rsp0_valid}, 1);
    chk("A data hold",  rsp_data, 12);
    rsp0_ready = 1'b1;
    tick(); rsp0_ready = 1'b0; #1;
    chk("A rsp0v done", {31'd0, rsp0_valid}, 0);
    chk("A idle",       {31'd0, busy}, 0);

    // Both valid, responses always taken: grants alternate 1,0,1,0 (last was 0)
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_opcode = 5'd1; req0_a = 32'd20;  req0_b = 32'd3;
    req1_valid = 1'b1; req1_opcode = 5'd0; req1_a = 32'd100; req1_b = 32'd1;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic own;
      own = (k % 2 == 0);
      chk($sformatf("F%0d ready0", k), {31'd0, req0_ready}, {31'd0, !own});
      chk($sformatf("F%0d ready1", k), {31'd0, req1_ready}, {31'd0, own});
      tick(); #1;
      chk($sformatf("F%0d start", k), {31'd0, alu_start}, 1);
      chk($sformatf("F%0d alu_a", k), alu_a, own ? 32'd100 : 32'd20);
      tick();
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      chk($sformatf("F%0d rsp0v", k), {31'd0, rsp0_valid}, {31'd0, !own});
      chk($sformatf("F%0d rsp1v", k), {31'd0, rsp1_valid}, {31'd0, own});
      chk($sformatf("F%0d data", k), rsp_data, own ? 32'd101 : 32'd17);
      tick(); #1;
    end
    chk("F idle", {31'd0, busy}, 0);

    // Stalled response; non-owner rsp1_ready ignored; req1 waits
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_opcode = 5'd1; req0_a = 32'd50; req0_b = 32'd8;
    #1;
    chk("S ready0", {31'd0, req0_ready}, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_opcode = 5'd4; req1_a = 32'd3; req1_b = 32'd0; req1_shamt = 5'd2;
    #1;
    chk("S ready1 exec", {31'd0, req1_ready}, 0);
    tick(); #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("S%0d rsp0v", i), {31'd0, rsp0_valid}, 1);
      chk($sformatf("S%0d data", i), rsp_data, 42);
      chk($sformatf("S%0d busy", i), {31'd0, busy}, 1);
      chk($sformatf("S%0d ready1", i), {31'd0, req1_ready}, 0);
      chk($sformatf("S%0d rsp1v", i), {31'd0, rsp1_valid}, 0);
      tick(); #1;
    end
    rsp0_ready = 1'b1; #1;
    chk("S rsp0v at hs", {31'd0, rsp0_valid}, 1);
    chk("S ready1 at hs", {31'd0, req1_ready}, 0);
    tick(); rsp0_ready = 1'b0; #1;
    chk("S rsp0v after", {31'd0, rsp0_valid}, 0);
    chk("S ready1 after", {31'd0, req1_ready}, 1);
    tick(); req1_valid = 1'b0; #1;
    chk("S r1 start", {31'd0, alu_start}, 1);
    chk("S r1 shamt", {27'd0, alu_shamt}, 2);
    tick(); #1;
    chk("S r1 rsp1v", {31'd0, rsp1_valid}, 1);
    chk("S r1 data", rsp_data, 12);
    tick(); #1;
    chk("S r1 idle", {31'd0, busy}, 0);

    // Reset mid-EXEC
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd9; req0_b = 32'd9;
    #1;
    tick(); req0_valid = 1'b0; #1;
    chk("R busy exec", {31'd0, busy}, 1);
    resetn = 1'b0; #1;
    chk_all_zero("R async");
    #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("R%0d rsp0v", i), {31'd0, rsp0_valid}, 0);
      chk($sformatf("R%0d busy", i), {31'd0, busy}, 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("R first ready0", {31'd0, req0_ready}, 1);
    chk("R first ready1", {31'd0, req1_ready}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("R withdrawn idle", {31'd0, busy}, 0);

    // Latency 4: 1 << 31
    b_req1_valid = 1'b1; b_req1_opcode = 5'd4; b_req1_a = 32'd1; b_req1_shamt = 5'd31;
    #1;
    chk("L ready1", {31'd0, b_req1_ready}, 1);
    tick(); b_req1_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("L%0d op", i), {27'd0, b_alu_opcode}, 4);
      chk($sformatf("L%0d a", i), b_alu_a, 1);
      chk($sformatf("L%0d shamt", i), {27'd0, b_alu_shamt}, 31);
      chk($sformatf("L%0d start", i), {31'd0, b_alu_start}, (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("L%0d rsp1v", i), {31'd0, b_rsp1_valid}, 0);
      chk($sformatf("L%0d busy", i), {31'd0, b_busy}, 1);
      tick();
    end
    chk("L rsp1v@T+5", {31'd0, b_rsp1_valid}, 1);
    chk("L data@T+5", b_rsp_data, 32'h8000_0000);
    b_rsp1_ready = 1'b1;
    tick();
    chk("L idle", {31'd0, b_busy}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
